// File: rtl/noc_input_fifo.sv
// NoC router input FIFO: first-word fall-through circular buffer with credit return.
// Optional write-side packet framing checker is built when PKT_CHECK_EN is defined.

`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module noc_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] rx,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  empty,
    output logic                  full,
    output logic [1:0]            credit_out,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;

    logic candidate;
    logic do_write;
    logic do_pop;
    logic discard;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign candidate = valid_in & ~full;
    assign do_pop    = rd_en & ~empty;

    assign data_out = mem[rd_ptr];
    assign flit_id  = data_out[DATA_WIDTH-1:DATA_WIDTH-3];
    assign dst_addr = data_out[DATA_WIDTH-4:DATA_WIDTH-7];

`ifdef PKT_CHECK_EN
    typedef enum logic {IDLE, BODY} frame_state_t;

    frame_state_t state, state_next;
    logic [2:0]   rx_id;

    assign rx_id = rx[DATA_WIDTH-1:DATA_WIDTH-3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        discard    = 1'b0;
        if (candidate) begin
            case (state)
                IDLE: begin
                    if (rx_id == `HEADER) begin
                        do_write   = 1'b1;
                        state_next = BODY;
                    end else begin
                        discard = 1'b1;
                    end
                end
                BODY: begin
                    if (rx_id == `PAYLOAD) begin
                        do_write = 1'b1;
                    end else if (rx_id == `TAIL) begin
                        do_write   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        discard = 1'b1;
                    end
                end
                default: discard = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_err <= 1'b0;
        else      frame_err <= discard;
    end
`else
    assign do_write  = candidate;
    assign discard   = 1'b0;
    assign frame_err = 1'b0;
`endif

    // NOTE: the storage array has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= rx;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            credit_out <= 2'd0;
            overflow   <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            credit_out <= {1'b0, do_pop} + {1'b0, discard};
            if (valid_in && full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_input_fifo.sv
// Self-checking bench for noc_input_fifo: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.

`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module tb_noc_input_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] rx;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic [2:0]    flit_id;
    logic [3:0]    dst_addr;
    logic          empty;
    logic          full;
    logic [1:0]    credit_out;
    logic          overflow;
    logic          frame_err;

    noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rx(rx), .rd_en(rd_en),
        .data_out(data_out), .flit_id(flit_id), .dst_addr(dst_addr),
        .empty(empty), .full(full), .credit_out(credit_out),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] q[$];
    int            m_credit;
    bit            m_overflow;
    bit            m_ferr;
    bit            m_in_pkt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] flit(input logic [2:0] id, input logic [3:0] dst);
        logic [DW-8:0] body;
        body = DW'($urandom);
        return {id, dst, body[DW-8:0]};
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".empty"}, empty, q.size() == 0);
        check({tag, ".full"}, full, q.size() == DEPTH);
        check({tag, ".credit"}, credit_out, m_credit);
        check({tag, ".overflow"}, overflow, m_overflow);
        check({tag, ".frame_err"}, frame_err, m_ferr);
        if (q.size() > 0) begin
            check({tag, ".data"}, data_out, q[0]);
            check({tag, ".flit_id"}, flit_id, q[0][DW-1:DW-3]);
            check({tag, ".dst"}, dst_addr, q[0][DW-4:DW-7]);
        end
    endtask

    // Called at a falling edge: drive inputs, advance model, clock, compare.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d, input logic r);
        bit pop, wr, disc;
        logic [2:0] id;
        valid_in = v;
        rx       = d;
        rd_en    = r;
        pop  = r && q.size() > 0;
        wr   = 0;
        disc = 0;
        if (v && q.size() == DEPTH) begin
            m_overflow = 1;
        end else if (v) begin
`ifdef PKT_CHECK_EN
            id = d[DW-1:DW-3];
            if (!m_in_pkt) begin
                if (id == `HEADER) begin wr = 1; m_in_pkt = 1; end
                else disc = 1;
            end else begin
                if (id == `PAYLOAD) wr = 1;
                else if (id == `TAIL) begin wr = 1; m_in_pkt = 0; end
                else disc = 1;
            end
`else
            id = d[DW-1:DW-3];
            wr = (id == id);
`endif
        end
        if (pop) void'(q.pop_front());
        if (wr) q.push_back(d);
        m_credit = int'(pop) + int'(disc);
        m_ferr   = disc;
        @(posedge clk);
        @(negedge clk);
        valid_in = 0;
        rd_en    = 0;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        valid_in = 0;
        rd_en    = 0;
        #2 rst = 0;
        #1;
        q.delete();
        m_credit   = 0;
        m_overflow = 0;
        m_ferr     = 0;
        m_in_pkt   = 0;
        check_all({tag, ".rst"});
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        logic [DW-1:0] f;
        logic [2:0]    ids [4];
        ids[0] = `HEADER; ids[1] = `PAYLOAD; ids[2] = `TAIL; ids[3] = 3'b111;

        rst = 0; valid_in = 0; rd_en = 0; rx = '0;
        q.delete(); m_credit = 0; m_overflow = 0; m_ferr = 0; m_in_pkt = 0;
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1;

        // Packet of three flits, head visible one cycle after first write
        cycle("pkt.h", 1, flit(`HEADER, 4'hA), 0);
        check("pkt.h.id", flit_id, `HEADER);
        check("pkt.h.dst", dst_addr, 4'hA);
        cycle("pkt.p", 1, flit(`PAYLOAD, 4'h0), 0);
        cycle("pkt.t", 1, flit(`TAIL, 4'h0), 0);
        check("pkt.count3", q.size(), 3);
        check("pkt.not_empty", empty, 1'b0);

        // Fill to full, fifth write dropped, overflow sticky, drain in order
        async_reset("ovf");
        cycle("ovf.w1", 1, flit(`HEADER, 4'h1), 0);
        cycle("ovf.w2", 1, flit(`PAYLOAD, 4'h2), 0);
        cycle("ovf.w3", 1, flit(`PAYLOAD, 4'h3), 0);
        cycle("ovf.w4", 1, flit(`TAIL, 4'h4), 0);
        check("ovf.full", full, 1'b1);
        cycle("ovf.w5", 1, flit(`HEADER, 4'h5), 0);
        check("ovf.sticky", overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("ovf.order", dst_addr, 4'(i + 1));
            cycle("ovf.pop", 0, '0, 1);
            check("ovf.credit", credit_out, 2'd1);
        end
        check("ovf.still", overflow, 1'b1);

        // Write and pop together while full: write dropped, pop taken
        async_reset("fullrw");
        cycle("fullrw.w1", 1, flit(`HEADER, 4'h1), 0);
        cycle("fullrw.w2", 1, flit(`PAYLOAD, 4'h2), 0);
        cycle("fullrw.w3", 1, flit(`PAYLOAD, 4'h3), 0);
        cycle("fullrw.w4", 1, flit(`TAIL, 4'h4), 0);
        cycle("fullrw.rw", 1, flit(`HEADER, 4'h9), 1);
        check("fullrw.count3", full, 1'b0);
        check("fullrw.head", dst_addr, 4'h2);

        // Pointer wrap: fill, pop 3, write 3, drain
        async_reset("wrap");
        cycle("wrap.w", 1, flit(`HEADER, 4'h1), 0);
        for (int i = 0; i < 3; i++) cycle("wrap.w", 1, flit(`PAYLOAD, 4'(i + 2)), 0);
        for (int i = 0; i < 3; i++) cycle("wrap.p", 0, '0, 1);
        cycle("wrap.w", 1, flit(`PAYLOAD, 4'h5), 0);
        cycle("wrap.w", 1, flit(`PAYLOAD, 4'h6), 0);
        cycle("wrap.w", 1, flit(`TAIL, 4'h7), 0);
        for (int i = 0; i < 4; i++) cycle("wrap.drain", 0, '0, 1);

        // Write and pop together while empty: write wins, pop ignored
        cycle("emptyrw", 1, flit(`HEADER, 4'hC), 1);
        check("emptyrw.ne", empty, 1'b0);

`ifdef PKT_CHECK_EN
        // Framing violation together with a pop
        async_reset("frm");
        cycle("frm.h", 1, flit(`HEADER, 4'h1), 0);
        cycle("frm.t", 1, flit(`TAIL, 4'h1), 0);
        cycle("frm.bad", 1, flit(`PAYLOAD, 4'h3), 1);
        check("frm.err", frame_err, 1'b1);
        check("frm.credit2", credit_out, 2'd2);
        cycle("frm.after", 0, '0, 0);
        check("frm.pulse", frame_err, 1'b0);
`endif

        // Reset with two flits stored, mid-cycle
        async_reset("mid");
        cycle("mid.w", 1, flit(`HEADER, 4'h1), 0);
        cycle("mid.w", 1, flit(`PAYLOAD, 4'h2), 0);
        async_reset("mid2");
        cycle("mid.slot0", 1, flit(`HEADER, 4'hE), 0);
        check("mid.slot0.dst", dst_addr, 4'hE);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd");
            end else begin
                f = flit(ids[$urandom_range(0, 3)], 4'($urandom));
                cycle("rnd", 1'($urandom_range(0, 99) < 55), f, 1'($urandom_range(0, 99) < 45));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
